// File: rtl/full_add_pkg.sv
// full_add_pkg: width constants for the registered ripple-carry adder
package full_add_pkg;
  localparam int DEF_B = 8;
  localparam int MAX_B = 64;
endpackage

// File: rtl/full_add_bit.sv
// full_add_bit: one-bit combinational full adder cell of the ripple chain
module full_add_bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  logic p;
  always_comb begin
    p    = a ^ b;
    s    = p ^ cin;
    cout = (a & b) | (cin & p);
  end
endmodule

// File: rtl/full_add.sv
// full_add: B-bit ripple adder with registered sum/carry; FULL_ADD_OVF_EN adds a registered signed-overflow flag
module full_add
  import full_add_pkg::*;
#(
  parameter int B = DEF_B
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [B-1:0] a,
  input  logic [B-1:0] b,
  input  logic         ca,
  input  logic         in_valid,
  output logic [B-1:0] su,
  output logic         co,
  output logic         out_valid
`ifdef FULL_ADD_OVF_EN
  ,
  output logic         ovf
`endif
);
  logic [B:0]   c;
  logic [B-1:0] s;
  logic [B-1:0] su_d, su_q;
  logic         co_d, co_q, vld_d, vld_q;
  assign c[0] = ca;
  for (genvar i = 0; i < B; i++) begin : g_rip
    full_add_bit u_bit (
      .a   (a[i]),
      .b   (b[i]),
      .cin (c[i]),
      .s   (s[i]),
      .cout(c[i+1])
    );
  end
  always_comb begin
    su_d  = in_valid ? s : su_q;
    co_d  = in_valid ? c[B] : co_q;
    vld_d = in_valid;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      su_q  <= '0;
      co_q  <= 1'b0;
      vld_q <= 1'b0;
    end else begin
      su_q  <= su_d;
      co_q  <= co_d;
      vld_q <= vld_d;
    end
  end
  assign su        = su_q;
  assign co        = co_q;
  assign out_valid = vld_q;
`ifdef FULL_ADD_OVF_EN
  logic ovf_d, ovf_q;
  always_comb ovf_d = in_valid ? ((a[B-1] == b[B-1]) && (s[B-1] != a[B-1])) : ovf_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ovf_q <= 1'b0;
    else ovf_q <= ovf_d;
  end
  assign ovf = ovf_q;
`endif
endmodule

// File: tb/tb_full_add.sv
// tb_full_add: directed self-checking bench for full_add at B=8
module tb_full_add;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] a = '0, b = '0;
  logic       ca = 1'b0, in_valid = 1'b0;
  logic [7:0] su;
  logic       co, out_valid;
  int         errors = 0, checks = 0;
`ifdef FULL_ADD_OVF_EN
  logic       ovf;
`endif

  full_add #(.B(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .a        (a),
    .b        (b),
    .ca       (ca),
    .in_valid (in_valid),
    .su       (su),
    .co       (co),
    .out_valid(out_valid)
`ifdef FULL_ADD_OVF_EN
    ,
    .ovf      (ovf)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic op(input logic [7:0] ia, input logic [7:0] ib, input logic ic, input logic iv);
    a = ia; b = ib; ca = ic; in_valid = iv;
    @(posedge clk);
    #1;
  endtask

  task automatic res(input string tag, input logic [7:0] es, input logic ec, input logic ev);
    chk({tag, ".su"}, 64'(su), 64'(es));
    chk({tag, ".co"}, 64'(co), 64'(ec));
    chk({tag, ".vld"}, 64'(out_valid), 64'(ev));
  endtask

  initial begin
    a = 8'hFF; b = 8'hFF; ca = 1'b1; in_valid = 1'b1;
    #12;
    res("reset", 8'h00, 1'b0, 1'b0);
`ifdef FULL_ADD_OVF_EN
    chk("reset.ovf", 64'(ovf), 64'd0);
`endif
    rst_n = 1'b1;
    op(8'h0F, 8'hCC, 1'b0, 1'b1);
    res("first", 8'hDB, 1'b0, 1'b1);
    op(8'h6A, 8'hD5, 1'b0, 1'b1);
    res("b2b0", 8'h3F, 1'b1, 1'b1);
`ifdef FULL_ADD_OVF_EN
    chk("b2b0.ovf", 64'(ovf), 64'd0);
`endif
    op(8'h7F, 8'hE2, 1'b0, 1'b1);
    res("b2b1", 8'h61, 1'b1, 1'b1);
    op(8'h09, 8'hCA, 1'b0, 1'b1);
    res("b2b2", 8'hD3, 1'b0, 1'b1);
    op(8'hFF, 8'h00, 1'b1, 1'b1);
    res("wrap", 8'h00, 1'b1, 1'b1);
    op(8'h01, 8'h01, 1'b1, 1'b1);
    res("cin", 8'h03, 1'b0, 1'b1);
    op(8'h7F, 8'h01, 1'b0, 1'b1);
    res("pos_ovf", 8'h80, 1'b0, 1'b1);
`ifdef FULL_ADD_OVF_EN
    chk("pos_ovf.ovf", 64'(ovf), 64'd1);
`endif
    op(8'hFF, 8'hFF, 1'b1, 1'b1);
    res("max", 8'hFF, 1'b1, 1'b1);
    op(8'h12, 8'h34, 1'b0, 1'b0);
    res("hold", 8'hFF, 1'b1, 1'b0);
    op(8'h80, 8'h80, 1'b0, 1'b1);
    res("neg_ovf", 8'h00, 1'b1, 1'b1);
`ifdef FULL_ADD_OVF_EN
    chk("neg_ovf.ovf", 64'(ovf), 64'd1);
    op(8'h00, 8'h00, 1'b0, 1'b0);
    chk("hold.ovf", 64'(ovf), 64'd1);
`endif
    op(8'h10, 8'h20, 1'b0, 1'b1);
    res("pre_rst", 8'h30, 1'b0, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    res("async_rst", 8'h00, 1'b0, 1'b0);
`ifdef FULL_ADD_OVF_EN
    chk("async_rst.ovf", 64'(ovf), 64'd0);
`endif
    op(8'h55, 8'h55, 1'b0, 1'b1);
    res("in_rst", 8'h00, 1'b0, 1'b0);
    rst_n = 1'b1;
    op(8'hA5, 8'h5A, 1'b1, 1'b1);
    res("after_rst", 8'h00, 1'b1, 1'b1);
    op(8'h00, 8'h00, 1'b0, 1'b0);
    res("idle", 8'h00, 1'b1, 1'b0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/full_add.md
FULL_ADD -- requirements
Module: full_add

Interface
REQ-001 Parameter: B, default 8, operand/sum width in bits; legal range 1..64.
REQ-002 Port: clk  input  1  clock; all registers update on the rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 Port: a  input  B  operand A, unsigned (two's complement when the overflow flag is used).
REQ-005 Port: b  input  B  operand B, same encoding as a.
REQ-006 Port: ca  input  1  carry-in.
REQ-007 Port: in_valid  input  1  a, b and ca are valid this cycle.
REQ-008 Port: su  output  B  registered sum.
REQ-009 Port: co  output  1  registered carry-out.
REQ-010 Port: out_valid  output  1  su/co (and ovf) hold the result of an accepted operation.
REQ-011 Port: ovf  output  1  registered signed overflow; present only when FULL_ADD_OVF_EN is defined.

Function
REQ-012 The block SHALL compute {co, su} = a + b + ca as an unsigned (B+1)-bit result with no truncation before the carry-out.
REQ-013 Latency SHALL be exactly 1 cycle: operands sampled with in_valid=1 at edge N appear on su/co with out_valid=1 after edge N.
REQ-014 A new operation SHALL be accepted every cycle; there is no backpressure.
REQ-015 When in_valid=0 at an edge, su/co/ovf SHALL hold their previous values and out_valid SHALL go to 0.
REQ-016 Wrap-around: all-ones + all-zeros + ca=1 SHALL yield su=0, co=1.
REQ-017 ovf SHALL be 1 exactly when a[B-1]==b[B-1] and su[B-1]!=a[B-1], computed on the same operands as su.
REQ-018 For B=1 the block SHALL behave as a single registered full adder.

Reset
REQ-019 While rst_n=0: su=0, co=0, out_valid=0, ovf=0, independent of clk.
REQ-020 Reset assertion mid-operation SHALL discard the in-flight result.
REQ-021 The first operation SHALL be accepted on the first rising edge with rst_n=1 and in_valid=1.

Configuration
REQ-022 Macro FULL_ADD_OVF_EN: when defined, the ovf port and its register exist per REQ-017.
REQ-023 When FULL_ADD_OVF_EN is not defined, the ovf port and its logic are absent; all other behaviour is identical.

Structure
REQ-024 Package full_add_pkg SHALL hold the default width constant (8) and the maximum-width constant (64).
REQ-025 The sum SHALL be built from a ripple chain of B instances of sub-module full_add_bit (1-bit a, b, cin -> s, cout), generated by the parameter; the final cout feeds co.
REQ-026 Only the output stage is registered; the ripple chain is combinational.

Verification (B=8, ca=0 unless stated, in_valid=1)
REQ-027 a=00001111, b=11001100 -> su=11011011, co=0 one cycle later; out_valid=1.
REQ-028 Back-to-back on consecutive cycles: 01101010+11010101 -> su=00111111, co=1; then 01111111+11100010 -> su=01100001, co=1; then 00001001+11001010 -> su=11010011, co=0.
REQ-029 a=11111111, b=00000000, ca=1 -> su=00000000, co=1.
REQ-030 With FULL_ADD_OVF_EN: a=01111111, b=00000001 -> su=10000000, co=0, ovf=1; a=01101010, b=11010101 -> ovf=0.
REQ-031 Assert rst_n=0 between clock edges while out_valid=1 -> su, co, out_valid and ovf go to 0 immediately; in_valid=0 with rst_n=1 -> out_valid=0 and su/co unchanged.
